// File: rtl/tog_hs_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tog_hs_tx : source-side transmitter of a toggle-handshake CDC.           |
// |   Holds one word, flips req_tog, waits for the resynchronised ack.       |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tog_hs_tx #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2,   // legal range 2..4
  parameter int TIMEOUT     = 64   // 0 disables the timeout
) (
  input  logic         clkA,
  input  logic         rst_n,
  input  logic [N-1:0] data_in,
  input  logic         valid_in,
  output logic         ready_out,
  output logic [N-1:0] data_out,
  output logic         req_tog,
  input  logic         ack_tog_in,
  output logic         busy,
  output logic         done_pulse,
  output logic         timeout_err,
  input  logic         clr_err
);

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SYNC_STAGES-1:0] ack_sh;
  logic [SYNC_STAGES-1:0] prime_sh;
  logic                   ack_sync;
  logic                   primed;
  logic                   accept;
  logic                   ack_seen;

  // Plain flop chain; nothing combinational ahead of the first stage.
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      ack_sh <= '0;
    end else begin
      ack_sh <= {ack_sh[SYNC_STAGES-2:0], ack_tog_in};
    end
  end

  // The chain holds reset zeros, not the peer's level, until it has been
  // flushed; without this a peer left at ack=1 would look in phase briefly.
  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      prime_sh <= '0;
    end else begin
      prime_sh <= {prime_sh[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ack_sync = ack_sh[SYNC_STAGES-1];
  assign primed   = prime_sh[SYNC_STAGES-1];

  // Masking with done_pulse keeps an accept out of the completion cycle.
  assign ready_out = (state == S_IDLE) && primed && (ack_sync == req_tog) && !done_pulse;
  assign busy      = (state == S_WAIT);

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ack_seen  = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_in && ready_out) begin
          accept    = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_sync == req_tog) begin
          ack_seen  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkA or negedge rst_n) begin
    if (!rst_n) begin
      data_out   <= '0;
      req_tog    <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      done_pulse <= ack_seen;
      if (accept) begin
        data_out <= data_in;
        req_tog  <= ~req_tog;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

      logic [TW-1:0] timer;
      logic [TW-1:0] timer_inc;

      assign timer_inc = (timer == TMAX) ? timer : timer + 1'b1;

      always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
          timer <= '0;
        end else if (accept) begin
          timer <= '0;
        end else if (state == S_WAIT) begin
          timer <= timer_inc;
        end
      end

      // Set only on the edge the timer first reaches the limit; set beats clear.
      always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
          timeout_err <= 1'b0;
        end else if ((state == S_WAIT) && (timer != TMAX) && (timer_inc == TMAX)) begin
          timeout_err <= 1'b1;
        end else if (clr_err) begin
          timeout_err <= 1'b0;
        end
      end
    end else begin : g_no_timeout
      assign timeout_err = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tog_hs_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tog_hs_tx : directed self-checking bench for tog_hs_tx.               |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_tog_hs_tx;

  logic       clkA = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic [7:0] data_out;
  logic       req_tog;
  logic       ack_tog_in;
  logic       busy;
  logic       done_pulse;
  logic       timeout_err;
  logic       clr_err;

  logic       loop_en;
  logic       ack_man;
  logic [2:0] loop_pipe = 3'b000;

  int passed = 0;
  int total  = 0;

  always #5 clkA = ~clkA;

  // Destination stand-in: echoes req_tog back after three clkA cycles.
  always @(posedge clkA) loop_pipe <= {loop_pipe[1:0], req_tog};
  assign ack_tog_in = loop_en ? loop_pipe[2] : ack_man;

  tog_hs_tx #(.N(8), .SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clkA        (clkA),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .data_out    (data_out),
    .req_tog     (req_tog),
    .ack_tog_in  (ack_tog_in),
    .busy        (busy),
    .done_pulse  (done_pulse),
    .timeout_err (timeout_err),
    .clr_err     (clr_err)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clkA);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int dones;
    int dones_before;
    int acc2_at;
    logic busy_ok;
    logic hold_ok;
    logic seen_done;

    rst_n    = 1'b0;
    data_in  = 8'h00;
    valid_in = 1'b0;
    clr_err  = 1'b0;
    loop_en  = 1'b0;
    ack_man  = 1'b0;

    // 1: reset state
    step(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req", req_tog, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_done", done_pulse, 1'b0);
    chk("rst_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    step(2);
    chk("rst_ready", ready_out, 1'b1);

    // 2: single transfer through 3-cycle loopback; done 3+2+1 edges after accept
    loop_en  = 1'b1;
    data_in  = 8'hAA;
    valid_in = 1'b1;
    step(1);
    valid_in = 1'b0;
    chk("t2_data", data_out, 8'hAA);
    chk("t2_req", req_tog, 1'b1);
    chk("t2_ready_low", ready_out, 1'b0);
    cnt = 0;
    busy_ok = 1'b1;
    while (!done_pulse && cnt < 20) begin
      if (!busy) busy_ok = 1'b0;
      step(1);
      cnt++;
    end
    chk("t2_done_latency", cnt, 6);
    chk("t2_busy_held", busy_ok, 1'b1);
    chk("t2_ready_with_done", ready_out, 1'b0);
    step(1);
    chk("t2_done_width", done_pulse, 1'b0);
    chk("t2_ready_back", ready_out, 1'b1);

    // 3: back-to-back with valid held; second accept waits for the first done
    data_in  = 8'hAA;
    valid_in = 1'b1;
    step(1);
    chk("t3_req_first", req_tog, 1'b0);
    chk("t3_data_first", data_out, 8'hAA);
    data_in = 8'hFF;
    dones = 0;
    dones_before = -1;
    acc2_at = -1;
    hold_ok = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step(1);
      if (done_pulse) dones++;
      if (acc2_at < 0 && req_tog !== 1'b0) begin
        acc2_at = i;
        dones_before = dones;
        valid_in = 1'b0;
      end
      if (acc2_at < 0 && data_out !== 8'hAA) hold_ok = 1'b0;
    end
    chk("t3_second_accept_at", acc2_at, 8);
    chk("t3_done_before_2nd", dones_before, 1);
    chk("t3_data_held", hold_ok, 1'b1);
    chk("t3_done_count", dones, 2);
    chk("t3_req_second", req_tog, 1'b1);
    chk("t3_data_second", data_out, 8'hFF);

    // 4: timeout with ack frozen, then late ack and clear
    ack_man  = 1'b1;
    loop_en  = 1'b0;
    data_in  = 8'h55;
    valid_in = 1'b1;
    step(1);
    valid_in = 1'b0;
    chk("t4_data", data_out, 8'h55);
    step(7);
    chk("t4_err_early", timeout_err, 1'b0);
    step(1);
    chk("t4_err_set", timeout_err, 1'b1);
    chk("t4_busy", busy, 1'b1);
    step(3);
    chk("t4_still_busy", busy, 1'b1);
    ack_man = 1'b0;
    step(3);
    chk("t4_done", done_pulse, 1'b1);
    chk("t4_err_sticky", timeout_err, 1'b1);
    step(2);
    chk("t4_err_sticky2", timeout_err, 1'b1);
    chk("t4_ready", ready_out, 1'b1);
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t4_err_clr", timeout_err, 1'b0);

    // 5: peer left at ack=1 across reset
    ack_man = 1'b1;
    rst_n   = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(4);
    chk("t5_ready_low", ready_out, 1'b0);
    data_in  = 8'h33;
    valid_in = 1'b1;
    step(1);
    valid_in = 1'b0;
    chk("t5_ignored_busy", busy, 1'b0);
    chk("t5_ignored_req", req_tog, 1'b0);
    chk("t5_ignored_data", data_out, 8'h00);
    ack_man = 1'b0;
    step(1);
    chk("t5_ready_wait", ready_out, 1'b0);
    step(1);
    chk("t5_ready_up", ready_out, 1'b1);

    // 6: reset in the middle of WAIT
    data_in  = 8'hC3;
    valid_in = 1'b1;
    step(1);
    valid_in = 1'b0;
    step(2);
    chk("t6_busy_pre", busy, 1'b1);
    chk("t6_data_pre", data_out, 8'hC3);
    rst_n = 1'b0;
    #1;
    chk("t6_busy_rst", busy, 1'b0);
    chk("t6_req_rst", req_tog, 1'b0);
    chk("t6_data_rst", data_out, 8'h00);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rst_n = 1'b1;
      step(1);
      if (done_pulse) seen_done = 1'b1;
    end
    chk("t6_no_done", seen_done, 1'b0);
    chk("t6_ready_after", ready_out, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
